// File: rtl/fifo_uart_tx_if.sv
// Bus between the FIFO/control side and the UART transmit drain stage.
// The master side owns the FIFO status, the FIFO read data and the transmit enable.
// The slave side is the transmitter: it returns the read strobe, the serial line and status.
interface fifo_uart_tx_if;
  logic        en;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;

  modport master (
    output en, fifo_empty, fifo_data,
    input  fifo_rd, tx, busy, frame_cnt
  );

  modport slave (
    input  en, fifo_empty, fifo_data,
    output fifo_rd, tx, busy, frame_cnt
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous byte FIFO with a one-cycle read latency.
// Frame: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// All outputs except the FIFO read strobe are registered.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.slave  bus
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [2:0]    bit_cnt_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic          tx_reg;
  logic          busy_reg;
  logic [15:0]   frame_cnt_reg;
  logic          baud_last;

  assign baud_last = (baud_cnt_reg == BAUD_LAST);

  // Read strobe is only issued from IDLE; it is forced low while reset is held so the
  // FIFO is never popped during reset.
  assign bus.fifo_rd   = !rst && (state_reg == IDLE) && bus.en && !bus.fifo_empty;
  assign bus.tx        = tx_reg;
  assign bus.busy      = busy_reg;
  assign bus.frame_cnt = frame_cnt_reg;

  // Frame sequencer: tx/busy are set one cycle ahead so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= 8'h00;
      parity_reg    <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      baud_cnt_reg  <= '0;
      tx_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      frame_cnt_reg <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg       <= 1'b1;
          baud_cnt_reg <= '0;
          if (bus.en && !bus.fifo_empty) begin
            state_reg <= FETCH;
            busy_reg  <= 1'b1;
          end
        end
        FETCH: begin
          // FIFO read data is valid now, one cycle after the strobe.
          shift_reg    <= bus.fifo_data;
          parity_reg   <= ^bus.fifo_data;
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b0;
          state_reg    <= START;
        end
        START: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= 3'd0;
            tx_reg       <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              if (PARITY_EN) begin
                tx_reg    <= parity_reg;
                state_reg <= PARITY;
              end else begin
                tx_reg    <= 1'b1;
                state_reg <= STOP;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            state_reg    <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
            state_reg     <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
